// File: rtl/ysyx_23060124__ifu_fetch_if.sv
// Fetch-stage bus bundle: icache request/response, redirect port, decode handshake and perf counters.
// The master side is the fetch unit; the slave side is the surrounding pipeline and cache.
interface ysyx_23060124__ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic [DATA_WIDTH-1:0] ic_data;
  logic                  ic_hit;
  logic                  ic_fence_i;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  fence_i_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [31:0]           perf_fetch_cnt;
  logic [31:0]           perf_miss_cyc;

  modport master (
    input  ic_data, ic_hit, redirect_valid, redirect_pc, fence_i_req, out_ready,
    output ic_addr, ic_fence_i, out_valid, out_inst, out_pc, perf_fetch_cnt, perf_miss_cyc
  );

  modport slave (
    output ic_data, ic_hit, redirect_valid, redirect_pc, fence_i_req, out_ready,
    input  ic_addr, ic_fence_i, out_valid, out_inst, out_pc, perf_fetch_cnt, perf_miss_cyc
  );
endinterface

// File: rtl/ysyx_23060124__ifu_fetch.sv
// Instruction-fetch stage: owns the PC, captures icache hits into a small in-order queue for decode,
// and sequences redirects and fence.i (one invalidate cycle) toward the icache.
module ysyx_23060124__ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h3000_0000),
  parameter int                    QDEPTH     = 2
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_23060124__ifu_fetch_if.master  bus
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FENCE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic                  fence_q, fence_d;

  logic [DATA_WIDTH-1:0] inst_mem [QDEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QDEPTH];

  logic redirect, out_valid, pop, push, miss;

  assign redirect  = bus.redirect_valid;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign push      = (state_q == ST_RUN) && bus.ic_hit && !redirect &&
                     ((count_q < QDEPTH_C) || pop);
  assign miss      = (state_q == ST_RUN) && !bus.ic_hit && !redirect;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fetch_cnt_d = fetch_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FENCE: state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    if (redirect) begin
      // Flush drops any pop this cycle too; entries behind a redirect are wrong-path.
      state_d = bus.fence_i_req ? ST_FENCE : ST_RUN;
      pc_d    = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d        = pc_q + ADDR_WIDTH'(4);
        tail_d      = tail_q + PTR_W'(1);
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (miss) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  assign fence_d = (state_d == ST_FENCE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      miss_cnt_q  <= '0;
      fence_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fetch_cnt_q <= fetch_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      fence_q     <= fence_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= bus.ic_data;
      pc_mem[tail_q]   <= pc_q;
    end
  end

  assign bus.ic_addr        = pc_q;
  assign bus.ic_fence_i     = fence_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_inst       = out_valid ? inst_mem[head_q] : '0;
  assign bus.out_pc         = out_valid ? pc_mem[head_q] : '0;
  assign bus.perf_fetch_cnt = fetch_cnt_q;
  assign bus.perf_miss_cyc  = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_23060124__ifu_fetch.sv
// Directed bench for the fetch stage: the icache is modelled as returning ic_addr ^ KEY on a hit,
// and every expectation is a hand-derived constant for the cycle it is checked in.
module tb_ysyx_23060124__ifu_fetch;
  localparam logic [31:0] KEY  = 32'h1357_9BDF;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        hit_en = 1'b0;
  logic        rdr_valid = 1'b0;
  logic [31:0] rdr_pc = '0;
  logic        fence_req = 1'b0;
  logic        ready = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060124__ifu_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  assign bus.ic_hit         = hit_en;
  assign bus.ic_data        = bus.ic_addr ^ KEY;
  assign bus.redirect_valid = rdr_valid;
  assign bus.redirect_pc    = rdr_pc;
  assign bus.fence_i_req    = fence_req;
  assign bus.out_ready      = ready;

  ysyx_23060124__ifu_fetch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h3000_0000), .QDEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; hit_en = 1'b0; rdr_valid = 1'b0; fence_req = 1'b0; ready = 1'b0; rdr_pc = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.out_inst); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.out_pc); end
    checks++; if (bus.ic_addr !== BASE) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.ic_addr, BASE); end
    checks++; if (bus.ic_fence_i !== 1'b0) begin errors++; $display("FAIL reset_fence got %b exp 0", bus.ic_fence_i); end
    checks++; if (bus.perf_fetch_cnt !== 32'h0 || bus.perf_miss_cyc !== 32'h0) begin
      errors++; $display("FAIL reset_perf got %h/%h exp 0/0", bus.perf_fetch_cnt, bus.perf_miss_cyc);
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    hit_en = 1'b1; ready = 1'b1;
    step(); // BOOT edge: nothing pushed
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.ic_addr !== BASE) begin errors++; $display("FAIL boot_addr got %h exp %h", bus.ic_addr, BASE); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        step();
        hit_en = 1'b0;
      end else begin
        step();
      end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 32'(4 * i)) begin
        errors++; $display("FAIL fetch_pc%0d got %b/%h exp 1/%h", i, bus.out_valid, bus.out_pc, BASE + 32'(4 * i));
      end
      checks++; if (bus.out_inst !== ((BASE + 32'(4 * i)) ^ KEY)) begin
        errors++; $display("FAIL fetch_inst%0d got %h exp %h", i, bus.out_inst, (BASE + 32'(4 * i)) ^ KEY);
      end
    end
    checks++; if (bus.perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL fetch_cnt got %0d exp 3", bus.perf_fetch_cnt); end
    checks++; if (bus.ic_addr !== 32'h3000_000C) begin errors++; $display("FAIL fetch_addr got %h exp 3000000c", bus.ic_addr); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    hit_en = 1'b1; ready = 1'b0;
    step(); step(); step(); // BOOT, push 00, push 04
    step(); step();         // full, no pop: hold
    checks++; if (bus.ic_addr !== 32'h3000_0008) begin errors++; $display("FAIL full_addr got %h exp 30000008", bus.ic_addr); end
    checks++; if (bus.out_pc !== BASE || bus.out_inst !== (BASE ^ KEY)) begin
      errors++; $display("FAIL full_head got %h/%h exp %h/%h", bus.out_pc, bus.out_inst, BASE, BASE ^ KEY);
    end
    checks++; if (bus.perf_fetch_cnt !== 32'd2) begin errors++; $display("FAIL full_cnt got %0d exp 2", bus.perf_fetch_cnt); end
    ready = 1'b1;
    step(); // pop 00, push 08 while full
    checks++; if (bus.out_pc !== 32'h3000_0004 || bus.ic_addr !== 32'h3000_000C) begin
      errors++; $display("FAIL pushpop1 got %h/%h exp 30000004/3000000c", bus.out_pc, bus.ic_addr);
    end
    step(); // pop 04, push 0C
    checks++; if (bus.out_pc !== 32'h3000_0008 || bus.perf_fetch_cnt !== 32'd4) begin
      errors++; $display("FAIL pushpop2 got %h/%0d exp 30000008/4", bus.out_pc, bus.perf_fetch_cnt);
    end
  endtask

  task automatic test_redirect();
    // Continues from test_back_to_back: two entries (08, 0C) queued.
    ready = 1'b0; rdr_valid = 1'b1; rdr_pc = 32'h8000_0013;
    step();
    rdr_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
      errors++; $display("FAIL redir_flush got %b/%h exp 0/0", bus.out_valid, bus.out_pc);
    end
    checks++; if (bus.ic_addr !== 32'h8000_0010) begin errors++; $display("FAIL redir_addr got %h exp 80000010", bus.ic_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0010 || bus.out_inst !== (32'h8000_0010 ^ KEY)) begin
      errors++; $display("FAIL redir_push got %b/%h/%h exp 1/80000010/%h", bus.out_valid, bus.out_pc, bus.out_inst, 32'h8000_0010 ^ KEY);
    end
    checks++; if (bus.perf_fetch_cnt !== 32'd5) begin errors++; $display("FAIL redir_cnt got %0d exp 5", bus.perf_fetch_cnt); end
  endtask

  task automatic test_fence();
    ready = 1'b1; hit_en = 1'b1;
    fence_req = 1'b1; // without redirect_valid this must be ignored
    step();
    checks++; if (bus.ic_fence_i !== 1'b0) begin errors++; $display("FAIL fence_unqual got %b exp 0", bus.ic_fence_i); end
    rdr_valid = 1'b1; rdr_pc = 32'h8000_0100;
    step();
    checks++; if (bus.ic_fence_i !== 1'b1 || bus.out_valid !== 1'b0 || bus.ic_addr !== 32'h8000_0100) begin
      errors++; $display("FAIL fence_enter got %b/%b/%h exp 1/0/80000100", bus.ic_fence_i, bus.out_valid, bus.ic_addr);
    end
    rdr_pc = 32'h8000_0202; // redirect+fence again during FENCE: one more FENCE cycle
    step();
    rdr_valid = 1'b0; fence_req = 1'b0;
    checks++; if (bus.ic_fence_i !== 1'b1 || bus.ic_addr !== 32'h8000_0200) begin
      errors++; $display("FAIL fence_repeat got %b/%h exp 1/80000200", bus.ic_fence_i, bus.ic_addr);
    end
    step(); // FENCE cycle: stale hit ignored
    checks++; if (bus.ic_fence_i !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL fence_nopush got %b/%b exp 0/0", bus.ic_fence_i, bus.out_valid);
    end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0200) begin
      errors++; $display("FAIL fence_target got %b/%h exp 1/80000200", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_miss();
    apply_reset();
    hit_en = 1'b0; ready = 1'b1;
    step(); // BOOT is not a miss cycle
    checks++; if (bus.perf_miss_cyc !== 32'd0) begin errors++; $display("FAIL miss_boot got %0d exp 0", bus.perf_miss_cyc); end
    repeat (7) step();
    checks++; if (bus.perf_miss_cyc !== 32'd7 || bus.ic_addr !== BASE || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL miss_hold got %0d/%h/%b exp 7/%h/0", bus.perf_miss_cyc, bus.ic_addr, bus.out_valid, BASE);
    end
    hit_en = 1'b1;
    step();
    hit_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE || bus.perf_fetch_cnt !== 32'd1) begin
      errors++; $display("FAIL miss_push got %b/%h/%0d exp 1/%h/1", bus.out_valid, bus.out_pc, bus.perf_fetch_cnt, BASE);
    end
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.perf_miss_cyc !== 32'd8) begin
      errors++; $display("FAIL miss_single got %b/%0d exp 0/8", bus.out_valid, bus.perf_miss_cyc);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    hit_en = 1'b1; ready = 1'b0;
    step(); step(); step(); // BOOT, push 00, push 04
    checks++; if (bus.out_valid !== 1'b1 || bus.ic_addr !== 32'h3000_0008) begin
      errors++; $display("FAIL arst_pre got %b/%h exp 1/30000008", bus.out_valid, bus.ic_addr);
    end
    #2 rst = 1'b1; // mid-cycle, no clock edge before the check
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0) begin
      errors++; $display("FAIL arst_out got %b/%h/%h exp 0/0/0", bus.out_valid, bus.out_inst, bus.out_pc);
    end
    checks++; if (bus.ic_addr !== BASE || bus.perf_fetch_cnt !== 32'h0 || bus.ic_fence_i !== 1'b0) begin
      errors++; $display("FAIL arst_state got %h/%0d/%b exp %h/0/0", bus.ic_addr, bus.perf_fetch_cnt, bus.ic_fence_i, BASE);
    end
    step();
    rst = 1'b0;
    step(); // BOOT again
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_boot got %b exp 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE) begin
      errors++; $display("FAIL arst_resume got %b/%h exp 1/%h", bus.out_valid, bus.out_pc, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_redirect();
    test_fence();
    test_miss();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060124__ifu_fetch.md
# ysyx_23060124__ifu_fetch

Instruction-fetch stage sitting directly upstream of the instruction cache. It owns the program counter, presents the fetch address to the cache, captures each hit instruction together with its PC into a small in-order queue, and hands them to decode over a valid/ready handshake. It also handles control-flow redirects and `fence.i` sequencing toward the cache.

## Interface
- `ADDR_WIDTH`, 32, PC / fetch address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h3000_0000, PC value after reset
- `QDEPTH`, 2, fetch-queue entries (power of two, ≥2)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `ic_addr` out ADDR_WIDTH: fetch address to the icache (registered PC)
- `ic_data` in DATA_WIDTH: instruction from the icache, valid when `ic_hit`
- `ic_hit` in 1: combinational hit for `ic_addr`
- `ic_fence_i` out 1: one-cycle cache-invalidate pulse
- `redirect_valid` in 1: execute stage requests a new PC
- `redirect_pc` in ADDR_WIDTH: target PC; bits [1:0] ignored (forced 0)
- `fence_i_req` in 1: qualifies `redirect_valid` as a `fence.i` redirect; ignored without it
- `out_valid` out 1: queue head valid to decode
- `out_ready` in 1: decode accepts head
- `out_inst` out DATA_WIDTH: head instruction (0 when empty)
- `out_pc` out ADDR_WIDTH: head PC (0 when empty)
- `perf_fetch_cnt` out 32: instructions pushed, wraps at 2^32
- `perf_miss_cyc` out 32: RUN cycles with `ic_hit`=0, wraps at 2^32

## Operation
- State machine: BOOT → RUN → (FENCE → RUN).
  - BOOT: one cycle after reset release; no push; goes to RUN.
  - RUN: normal fetch.
  - FENCE: one cycle; `ic_fence_i`=1; no push; goes to RUN. This cycle covers the stale hit that exists before the cache clears its valid bits.
- `pc` register drives `ic_addr`.
- Push condition (RUN only): `ic_hit` && !`redirect_valid` && (count < QDEPTH || pop this cycle).
  - On push, write {pc, `ic_data`} at the tail and set `pc <= pc + 4` (mod 2^ADDR_WIDTH).
- Pop: `out_valid` && `out_ready`; the head advances. Simultaneous push and pop leaves count unchanged; push is allowed when full if a pop occurs in the same cycle.
- Redirect (any state): flush the queue (count=0, `out_valid`=0 next cycle); `pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`; no push that cycle.
  - With `fence_i_req`, the next state is FENCE; otherwise RUN.
  - Redirect in BOOT is honoured and replaces `RESET_PC`.
  - Redirect during FENCE: take the new PC, and FENCE repeats for one more cycle only if `fence_i_req` is also set.
- Miss (RUN, !`ic_hit`): hold pc; the cache fetches autonomously.
- Queue full with hit and no pop: hold pc; no push.
- Counters: `perf_fetch_cnt` increments per push; `perf_miss_cyc` increments per RUN cycle with !`ic_hit` && !`redirect_valid`.

## Timing
- Reset values:
  - pc=`RESET_PC`, state=BOOT, queue empty
  - `out_valid`=0, `out_inst`=0, `out_pc`=0
  - `ic_fence_i`=0, both counters 0
  - `ic_addr`=`RESET_PC`
- Reset asserted mid-operation: all of the above takes effect immediately (asynchronous), and any queued entries are dropped.
- Hit-to-decode latency: push at edge N, `out_valid`=1 after edge N (registered queue, no bypass).
- Throughput: 1 instruction/cycle with continuous hits and `out_ready`=1.
- Redirect-to-fetch: new `ic_addr` is visible the cycle after `redirect_valid`; the first possible push is that same cycle (RUN) or one cycle later (FENCE).
- `out_inst`/`out_pc` are stable while `out_valid`=1 and `out_ready`=0.
- `ic_fence_i` is a registered output, high exactly in FENCE cycles.

## Test plan
- Reset release, `ic_hit`=1 with `ic_data`=PC-derived words, `out_ready`=1 → BOOT for one cycle; then pushes at 0x3000_0000, _0004, _0008 on consecutive cycles; `out_pc` follows one cycle later; `perf_fetch_cnt`=3.
- `out_ready`=0, hits continue → two entries queued, `ic_addr` frozen at 0x3000_0008. Raise `out_ready` → pops 0x3000_0000 then _0004, with push/pop on the same cycle when full.
- Queue holds 2 entries; `redirect_valid`=1, `redirect_pc`=0x8000_0013 → `out_valid`=0 next cycle; `ic_addr`=0x8000_0010; old entries never appear.
- `redirect_valid`+`fence_i_req` with `ic_hit` held high → `ic_fence_i` is a one-cycle pulse; no push in that cycle; push of the target in the following cycle.
- `ic_hit`=0 for 7 RUN cycles, then 1 → pc held; `perf_miss_cyc`=7; a single push follows.
- Assert `rst` asynchronously mid-stream with 2 entries queued → outputs reach their reset values immediately without a clock edge; BOOT follows reset release.
